// File: rtl/clk_div_pkg.sv
// Shared constants and state encoding for the run-time clock divider controller.
package clk_div_pkg;

  localparam int CNT_W        = 18;
  localparam int DEFAULT_HALF = 249999;
  localparam int MIN_HALF     = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND,
    STOP
  } state_e;

endpackage

// File: rtl/clk_div_sequencer_if.sv
// Control/status bundle between CSR logic (master) and clk_div_sequencer (slave).
// With CLK_DIV_SEQ_STATUS_EN defined the bundle also carries tick_cnt.
interface clk_div_sequencer_if #(
  parameter int CNT_W = 18
);

  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             tick;
  logic             busy;
`ifdef CLK_DIV_SEQ_STATUS_EN
  logic [15:0]      tick_cnt;

  modport master (output en, cfg_valid, cfg_half,
                  input  cfg_ready, cfg_err, clk_out, tick, busy, tick_cnt);
  modport slave  (input  en, cfg_valid, cfg_half,
                  output cfg_ready, cfg_err, clk_out, tick, busy, tick_cnt);
`else
  modport master (output en, cfg_valid, cfg_half,
                  input  cfg_ready, cfg_err, clk_out, tick, busy);
  modport slave  (input  en, cfg_valid, cfg_half,
                  output cfg_ready, cfg_err, clk_out, tick, busy);
`endif

endinterface

// File: rtl/clk_div_core.sv
// Half-period counter, toggle flop and tick register of the toggle-type divider.
// 'load' updates the terminal count; 'run' low parks the counter at 0 and clk_out low.
module clk_div_core #(
  parameter int CNT_W        = clk_div_pkg::CNT_W,
  parameter int DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] half,
  output logic             tc,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  assign tc      = (cnt_q == half_q);
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

  always_comb begin
    cnt_d     = cnt_q;
    half_d    = half_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    if (load) begin
      half_d = half;
    end
    if (!run) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
    end else if (tc) begin
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
      tick_d    = ~clk_out_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      half_q    <= CNT_W'(DEFAULT_HALF);
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

endmodule

// File: rtl/clk_div_sequencer.sv
// Start/stop and glitch-free reconfiguration controller around clk_div_core.
// Optional CLK_DIV_SEQ_STATUS_EN adds a saturating tick counter on the bus.
module clk_div_sequencer #(
  parameter int CNT_W        = clk_div_pkg::CNT_W,
  parameter int DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF
) (
  input logic                clk_50MHz,
  input logic                rst_n,
  clk_div_sequencer_if.slave bus
);

  import clk_div_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0] load_half;
  logic             xfer, cfg_bad, run, load, tc, clk_out, tick;

  assign bus.cfg_ready = (state_q == IDLE) || (state_q == RUN);
  assign bus.cfg_err   = cfg_err_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.clk_out   = clk_out;
  assign bus.tick      = tick;

  assign xfer    = bus.cfg_valid && bus.cfg_ready;
  assign cfg_bad = (bus.cfg_half < CNT_W'(MIN_HALF));
  // Counting only continues while both the current and next state are active,
  // so entering RUN starts from 0 and leaving to IDLE parks clk_out low.
  assign run     = (state_q != IDLE) && (state_d != IDLE);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cfg_err_d = 1'b0;
    load      = 1'b0;
    load_half = bus.cfg_half;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (cfg_bad) cfg_err_d = 1'b1;
          else         load      = 1'b1;
        end
        if (bus.en) state_d = RUN;
      end
      RUN: begin
        if (!bus.en) begin
          cfg_err_d = xfer;
          // A terminal count while high is itself the falling edge.
          state_d   = (!clk_out || tc) ? IDLE : STOP;
        end else if (xfer) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            pending_d = bus.cfg_half;
            state_d   = PEND;
          end
        end
      end
      PEND: begin
        if (tc) begin
          load      = 1'b1;
          load_half = pending_q;
          state_d   = RUN;
        end
      end
      STOP: begin
        if (bus.en)  state_d = RUN;
        else if (tc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  clk_div_core #(
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (DEFAULT_HALF)
  ) u_core (
    .clk     (clk_50MHz),
    .rst_n   (rst_n),
    .run     (run),
    .load    (load),
    .half    (load_half),
    .tc      (tc),
    .clk_out (clk_out),
    .tick    (tick)
  );

`ifdef CLK_DIV_SEQ_STATUS_EN
  logic [15:0] tick_cnt_q, tick_cnt_d;

  assign bus.tick_cnt = tick_cnt_q;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (state_q == IDLE && state_d == RUN) begin
      tick_cnt_d = '0;
    end else if (tick && tick_cnt_q != 16'hFFFF) begin
      tick_cnt_d = tick_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end
`endif

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Directed sequence with randomized half-periods; expected edge spacing is
// computed from the divider's period rule: each half lasts (half+1) cycles.
module tb_clk_div_sequencer;

  localparam int CNT_W = 18;
  localparam int DH    = 49;   // reduced default half keeps the run short
  localparam int BOUND = 400;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  clk_div_sequencer_if #(.CNT_W(CNT_W)) bus ();

  clk_div_sequencer #(
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (DH)
  ) dut (
    .clk_50MHz (clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
    $display("[TB] %-14s observed=%0d expected=%0d", tag, got, exp);
  endtask

  // Steps until clk_out reaches lvl; a timeout returns the bound, which no check expects.
  task automatic wait_out(input logic lvl, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.clk_out !== lvl && n < BOUND);
  endtask

  int n, m, h1, h2, h3, h4;

  initial begin
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_half  = '0;
    repeat (3) step();
    check("rst_clk_out", bus.clk_out, 0);
    check("rst_tick", bus.tick, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cfg_ready", bus.cfg_ready, 1);
`ifdef CLK_DIV_SEQ_STATUS_EN
    check("rst_tick_cnt", bus.tick_cnt, 0);
`endif
    rst_n = 1'b1;
    step();

    // Default half-period after reset
    bus.en = 1'b1;
    step();
    check("def_busy", bus.busy, 1);
    wait_out(1'b1, n);
    check("def_rise", n, DH + 1);
    check("def_tick_hi", bus.tick, 1);
    step();
    check("def_tick_lo", bus.tick, 0);
    wait_out(1'b0, n);
    check("def_high", n + 1, DH + 1);
    wait_out(1'b1, n);
    check("def_low", n, DH + 1);
    check("def_tick2", bus.tick, 1);

    // Stop while high: finishes the high half, then parks
    bus.en = 1'b0;
    step();
    check("stop_ready", bus.cfg_ready, 0);
    check("stop_busy", bus.busy, 1);
    wait_out(1'b0, n);
    check("stop_fall", n + 1, DH + 1);
    check("stop_idle", bus.busy, 0);
    step();
    check("stop_park", bus.clk_out, 0);

    // Config in IDLE, then a mid-half reconfiguration while running
    h1 = $urandom_range(3, 12);
    h2 = $urandom_range(2, 8);
    check("idle_ready", bus.cfg_ready, 1);
    bus.cfg_valid = 1'b1;
    bus.cfg_half  = CNT_W'(h1);
    step();
    bus.cfg_valid = 1'b0;
    check("idle_cfg_err", bus.cfg_err, 0);
    bus.en = 1'b1;
    step();
    wait_out(1'b1, n);
    check("h1_rise", n, h1 + 1);
    m = $urandom_range(1, h1 - 1);
    repeat (m) step();
    bus.cfg_valid = 1'b1;
    bus.cfg_half  = CNT_W'(h2);
    step();
    bus.cfg_valid = 1'b0;
    check("pend_ready", bus.cfg_ready, 0);
    wait_out(1'b0, n);
    check("h1_high", m + 1 + n, h1 + 1);
    check("switch_ready", bus.cfg_ready, 1);
    wait_out(1'b1, n);
    check("h2_low", n, h2 + 1);
    wait_out(1'b0, n);
    check("h2_high", n, h2 + 1);

    // Zero config rejected while running
    bus.cfg_valid = 1'b1;
    bus.cfg_half  = '0;
    step();
    bus.cfg_valid = 1'b0;
    check("run_zero_err", bus.cfg_err, 1);
    check("run_zero_rdy", bus.cfg_ready, 1);
    step();
    check("run_zero_pulse", bus.cfg_err, 0);
    wait_out(1'b1, n);
    check("run_zero_rise", n + 2, h2 + 1);
    wait_out(1'b0, n);
    m = n;
    wait_out(1'b1, n);
    check("run_zero_per", m + n, 2 * (h2 + 1));

    // Stop while low: IDLE on the next cycle
    wait_out(1'b0, n);
    check("h2_high2", n, h2 + 1);
    bus.en = 1'b0;
    step();
    check("lowstop_busy", bus.busy, 0);
    check("lowstop_out", bus.clk_out, 0);
    step();
    check("lowstop_park", bus.clk_out, 0);

    // Zero config rejected in IDLE; active half unchanged
    bus.cfg_valid = 1'b1;
    bus.cfg_half  = '0;
    step();
    bus.cfg_valid = 1'b0;
    check("idle_zero_err", bus.cfg_err, 1);
    step();
    check("idle_zero_pul", bus.cfg_err, 0);
    bus.en = 1'b1;
    step();
    wait_out(1'b1, n);
    check("idle_zero_rise", n, h2 + 1);
    bus.en = 1'b0;
    wait_out(1'b0, n);
    check("idle_zero_fall", n, h2 + 1);
    check("idle_zero_busy", bus.busy, 0);

    // Config and en in the same IDLE cycle
    h3 = $urandom_range(2, 10);
    bus.cfg_valid = 1'b1;
    bus.cfg_half  = CNT_W'(h3);
    bus.en        = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
    check("same_busy", bus.busy, 1);
    wait_out(1'b1, n);
    check("same_rise", n, h3 + 1);
    check("same_tick", bus.tick, 1);
    wait_out(1'b0, n);
    check("same_high", n, h3 + 1);
    wait_out(1'b1, n);
    check("same_low", n, h3 + 1);

    // Reset while a config is pending: it must be discarded
    h4 = h3 + $urandom_range(1, 5);
    bus.cfg_valid = 1'b1;
    bus.cfg_half  = CNT_W'(h4);
    step();
    bus.cfg_valid = 1'b0;
    check("rpend_ready", bus.cfg_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rpend_out", bus.clk_out, 0);
    check("rpend_busy", bus.busy, 0);
    check("rpend_ready1", bus.cfg_ready, 1);
    check("rpend_tick", bus.tick, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_busy", bus.busy, 1);
    wait_out(1'b1, n);
    check("post_rise", n, DH + 1);
`ifdef CLK_DIV_SEQ_STATUS_EN
    check("tcnt_before", bus.tick_cnt, 0);
    step();
    check("tcnt_one", bus.tick_cnt, 1);
    wait_out(1'b0, n);
    check("post_high", n + 1, DH + 1);
`else
    wait_out(1'b0, n);
    check("post_high", n, DH + 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
